// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: state encoding and phase-timer sizing shared by the pulse train generator
package pulse_gen_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  function automatic int timer_w(input int hi, input int lo);
    return $clog2(hi > lo ? hi : lo) + 1;
  endfunction
endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// phase_timer: loadable down-counter; expire marks the last cycle of a phase (count == 1)
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         expire
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (enable && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign expire = r_cnt == W'(1);
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits num pulses of HI_W cycles high separated by LO_W cycles low, then a done strobe
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int HI_W  = 1,
  parameter int LO_W  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);
  localparam int TW = timer_w(HI_W, LO_W);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_rem, w_rem, w_dec;
  logic [TW-1:0]    w_load_val;
  logic             w_load, w_expire, w_en;
  logic             r_out, r_busy, r_done;
  assign w_dec = (r_rem != '0) ? r_rem - CNT_W'(1) : r_rem;
  assign w_en  = r_state == HIGH || r_state == LOW;
  always_comb begin
    w_nxt      = r_state;
    w_rem      = r_rem;
    w_load     = 1'b0;
    w_load_val = TW'(HI_W);
    case (r_state)
      IDLE: if (start && !abort) begin
        w_nxt  = (num != '0) ? HIGH : DONE;
        w_rem  = num;
        w_load = 1'b1;
      end
      HIGH: if (w_expire) begin
        w_rem      = w_dec;
        w_nxt      = (w_dec == '0) ? DONE : LOW;
        w_load     = 1'b1;
        w_load_val = TW'(LO_W);
      end
      LOW: if (w_expire) begin
        w_nxt  = HIGH;
        w_load = 1'b1;
      end
      DONE: begin
        w_nxt = IDLE;
        w_rem = '0;
      end
    endcase
    // abort beats any phase progress, including the final decrement
    if (abort && r_state != IDLE) begin
      w_nxt = IDLE;
      w_rem = '0;
    end
  end
  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .enable   (w_en),
    .expire   (w_expire)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_rem   <= w_rem;
      r_out   <= w_nxt == HIGH;
      r_busy  <= w_nxt != IDLE;
      r_done  <= w_nxt == DONE;
    end
  assign out       = r_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign remaining = r_rem;
endmodule
